multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Control FSM that sequences a multicycle RV32I datapath (lw, sw, R-type, I-type ALU, beq, jal) sharing one ALU and one unified instruction/data memory.
- Decodes instr fields and drives the datapath mux selects and write strobes state by state.
- Stalls on a memory ready handshake.
- Sits beside the multicycle datapath inside the multicycle core top.

Parameters:
CNT_W, 32, width of performance counters (used only with MC_PERF_CNT_EN)

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low reset
op  in  7  instr[6:0]
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
Zero  in  1  ALU zero flag
MemReady  in  1  memory completes the current access this cycle
MemReq  out  1  memory access request, held until MemReady
MemWrite  out  1  write strobe, qualifies MemReq
AdrSrc  out  1  0 = PC, 1 = ALUOut
IRWrite  out  1  latch instruction and OldPC
PCWrite  out  1  PC register enable
RegWrite  out  1  register file write
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1
ALUSrcB  out  2  00 rs2, 01 imm, 10 const 4
ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
Illegal  out  1  one-cycle pulse on an undecodable opcode

Behaviour:
- State register resets asynchronously to S_RESET. All outputs are 0 in S_RESET. S_RESET goes to S_FETCH unconditionally on the next edge.
- Outputs are Moore-decoded from state, except:
  - PCWrite and IRWrite, which also depend on MemReady and Zero.
  - ImmSrc and ALUControl, which are decoded from op/funct.
- ALUOp by state:
  - 00 (add): FETCH, DECODE, MEMADR, JAL.
  - 01 (sub): BEQ.
  - 10 (funct decode): EXECR, EXECI.
- Funct decode:
  - funct3 000: sub when op[5] and funct7b5 are both 1, else add.
  - 010 → slt; 110 → or; 111 → and; any other funct3 → add.
- ImmSrc from op: lw/I-type → 00, sw → 01, beq → 10, jal → 11, otherwise 00.
- States:
  - FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10. When MemReady: IRWrite=1, PCWrite=1, go to DECODE; else hold with all outputs stable.
  - DECODE: ALUSrcA=01, ALUSrcB=01 (branch target into ALUOut). Next state by op:
    - 0000011 or 0100011 → MEMADR.
    - 0110011 → EXECR; 0010011 → EXECI.
    - 1100011 → BEQ; 1101111 → JAL.
    - else → FETCH with Illegal=1.
  - MEMADR: ALUSrcA=10, ALUSrcB=01. Goes to MEMREAD if op[5]=0, else MEMWR.
  - MEMREAD: MemReq=1, AdrSrc=1, ResultSrc=00. Goes to MEMWB on MemReady, else holds.
  - MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
  - MEMWR: MemReq=1, MemWrite=1, AdrSrc=1, ResultSrc=00. Goes to FETCH on MemReady, else holds.
  - EXECR: ALUSrcA=10, ALUSrcB=00 → ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01 → ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ResultSrc=00, PCWrite=Zero → FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1 → ALUWB.
- Latency with zero-wait memory (MemReady=1 throughout):
  - beq 3 cycles; R/I-type, sw, jal 4 cycles; lw 5 cycles.
  - Each wait cycle adds 1 cycle.
- Strobes outside the listed states are 0, and RegWrite/MemWrite never assert together.
- Reset asserted mid-instruction returns to S_RESET immediately. No partial write is issued after reset deasserts.
- MemReady outside a MemReq state is ignored.

Optional Feature:
- Macro MC_PERF_CNT_EN.
- Defined:
  - Adds outputs CycleCnt[CNT_W-1:0] and InstretCnt[CNT_W-1:0], both reset to 0.
  - CycleCnt increments every cycle outside S_RESET.
  - InstretCnt increments on each transition into FETCH from MEMWB, MEMWR, ALUWB or BEQ. Illegal returns do not count.
  - Both wrap modulo 2^CNT_W.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package mc_pkg holds:
  - statetype enum: S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL.
  - opcode constants: OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL.
  - ALUControl and ImmSrc encodings.
- Sub-module aludec_mc: combinational ALUOp/funct3/funct7b5/op[5] → ALUControl. It is instantiated once; the FSM and ImmSrc decode stay in the top.

Test Plan:
- Reset low for 3 cycles, then release → all outputs 0 during reset and the S_RESET cycle; the next cycle is FETCH with MemReq=1, AdrSrc=0.
- add x3,x1,x2 (op 0110011, funct3 000, funct7b5 0), MemReady=1 → FETCH, DECODE, EXECR (ALUControl 000), ALUWB (RegWrite=1), 4 cycles; with funct7b5=1, EXECR gives ALUControl 001.
- lw (op 0000011) with MemReady low for 2 cycles in MEMREAD → lw completes in 7 cycles; MemReq stays high and AdrSrc=1 throughout the wait; RegWrite=1 with ResultSrc=01 only in MEMWB.
- beq (op 1100011): with Zero=1 → PCWrite=1 in BEQ, ALUControl 001, ImmSrc 10; with Zero=0 → PCWrite=0; back in FETCH after 3 cycles.
- sw (op 0100011), then illegal op 1111111 → sw asserts MemWrite=1 with MemReq=1 in MEMWR only; the illegal op pulses Illegal=1 in DECODE, then FETCH, with no RegWrite or MemWrite.
- With MC_PERF_CNT_EN, run add, lw, beq, illegal, zero-wait → InstretCnt=3 and CycleCnt equals elapsed cycles minus 1 (the S_RESET cycle); a reset pulse mid-lw clears both counters and issues no RegWrite.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RV32I control path.
package mc_pkg;

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMREAD = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXECR   = 4'd7,
    S_EXECI   = 4'd8,
    S_ALUWB   = 4'd9,
    S_BEQ     = 4'd10,
    S_JAL     = 4'd11
  } statetype;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format selected by the opcode; unknown opcodes fall back to I.
  function automatic logic [1:0] imm_decode(input logic [6:0] op);
    case (op)
      OP_LW, OP_I: imm_decode = IMM_I;
      OP_SW:       imm_decode = IMM_S;
      OP_BEQ:      imm_decode = IMM_B;
      OP_JAL:      imm_decode = IMM_J;
      default:     imm_decode = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/aludec_mc.sv
// ALU decoder: maps ALUOp plus instruction function fields to ALUControl.
module aludec_mc
  import mc_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_op5,
  output logic [2:0] o_alu_control
);

  // Select the ALU operation; only R-type with funct7b5 set turns funct3=000 into sub.
  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_aluop)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          3'b000: begin
            if (i_op5 && i_funct7b5) o_alu_control = ALU_SUB;
            else                     o_alu_control = ALU_ADD;
          end
          3'b010:  o_alu_control = ALU_SLT;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// for lw, sw, R-type, I-type, beq and jal, stalling on MemReady.
// Optional build macro MC_PERF_CNT_EN adds CycleCnt/InstretCnt counters.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             Illegal
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] InstretCnt
`endif
);

  statetype   r_state;
  statetype   w_next_state;
  logic [1:0] w_aluop;

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("multicycle_controller: CNT_W must be at least 1");
  end

  // State register; reset drops straight back to S_RESET at any point.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_RESET;
    else        r_state <= w_next_state;
  end

  // Next-state logic; memory states hold until MemReady.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RESET:  w_next_state = S_FETCH;
      S_FETCH: begin
        if (MemReady) w_next_state = S_DECODE;
        else          w_next_state = S_FETCH;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_R:         w_next_state = S_EXECR;
          OP_I:         w_next_state = S_EXECI;
          OP_BEQ:       w_next_state = S_BEQ;
          OP_JAL:       w_next_state = S_JAL;
          default:      w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op[5]) w_next_state = S_MEMWR;
        else       w_next_state = S_MEMREAD;
      end
      S_MEMREAD: begin
        if (MemReady) w_next_state = S_MEMWB;
        else          w_next_state = S_MEMREAD;
      end
      S_MEMWB:  w_next_state = S_FETCH;
      S_MEMWR: begin
        if (MemReady) w_next_state = S_FETCH;
        else          w_next_state = S_MEMWR;
      end
      S_EXECR:  w_next_state = S_ALUWB;
      S_EXECI:  w_next_state = S_ALUWB;
      S_ALUWB:  w_next_state = S_FETCH;
      S_BEQ:    w_next_state = S_FETCH;
      S_JAL:    w_next_state = S_ALUWB;
      default:  w_next_state = S_RESET;
    endcase
  end

  // Output decode: Moore selects per state, PC/IR enables qualified by MemReady/Zero.
  always_comb begin
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    Illegal   = 1'b0;
    w_aluop   = ALUOP_ADD;
    if (r_state == S_RESET) ImmSrc = IMM_I;
    else                    ImmSrc = imm_decode(op);
    case (r_state)
      S_RESET: ;
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: Illegal = 1'b0;
          default:                                  Illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWR: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        w_aluop = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_aluop = ALUOP_FUNCT;
      end
      S_ALUWB:  RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = 2'b10;
        PCWrite = Zero;
        w_aluop = ALUOP_SUB;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
  end

  aludec_mc u_aludec (
    .i_aluop       (w_aluop),
    .i_funct3      (funct3),
    .i_funct7b5    (funct7b5),
    .i_op5         (op[5]),
    .o_alu_control (ALUControl)
  );

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;
  logic             w_retire;

  assign w_retire = (w_next_state == S_FETCH) &&
                    ((r_state == S_MEMWB) || (r_state == S_MEMWR) ||
                     (r_state == S_ALUWB) || (r_state == S_BEQ));

  // Cycle and retired-instruction counters; illegal-op returns do not retire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle_cnt   <= {CNT_W{1'b0}};
      r_instret_cnt <= {CNT_W{1'b0}};
    end else begin
      if (r_state != S_RESET) r_cycle_cnt <= r_cycle_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (w_retire) r_instret_cnt <= r_instret_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign CycleCnt   = r_cycle_cnt;
  assign InstretCnt = r_instret_cnt;
`endif

endmodule
